// File: rtl/shift_pkg.sv
// Shared mode and direction encodings for the universal shift register
// and its word-boundary counter.
package shift_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  localparam logic [1:0] DIR_NONE  = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;

  // Direction implied by a shift mode; only meaningful for MODE_SHR/MODE_SHL.
  function automatic logic [1:0] mode_to_dir(input logic [1:0] mode);
    return (mode == MODE_SHR) ? DIR_RIGHT : DIR_LEFT;
  endfunction

endpackage

// File: rtl/shift_word_counter.sv
// Counts consecutive same-direction shifts and pulses o_word_done when a
// full word of WIDTH shifts has gone by in one direction.
module shift_word_counter
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_shift,
  input  logic [1:0] i_dir,
  input  logic       i_clear,
  output logic       o_word_done
);

  localparam logic [CNT_W-1:0] CNT_WORD = CNT_W'(WIDTH);

  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_dir;
  logic             r_word_done;
  logic [CNT_W-1:0] w_cnt_inc;

  // A direction reversal starts a fresh word with this shift as its first bit.
  always_comb begin
    w_cnt_inc = r_cnt + 1'b1;
    if (r_dir != DIR_NONE && r_dir != i_dir) begin
      w_cnt_inc = CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt       <= '0;
      r_dir       <= DIR_NONE;
      r_word_done <= 1'b0;
    end else begin
      r_word_done <= 1'b0;
      if (i_clear) begin
        r_cnt <= '0;
        r_dir <= DIR_NONE;
      end else if (i_shift) begin
        r_dir <= i_dir;
        if (w_cnt_inc == CNT_WORD) begin
          r_cnt       <= '0;
          r_word_done <= 1'b1;
        end else begin
          r_cnt <= w_cnt_inc;
        end
      end
    end
  end

  assign o_word_done = r_word_done;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift right, shift left or parallel load,
// with per-direction serial ports and a word-completion pulse.
module univ_shift_reg
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic [WIDTH-1:0] pin,
  output logic [WIDTH-1:0] out,
  output logic             sout_r,
  output logic             sout_l,
  output logic             word_done
);

  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] w_data_next;
  logic             w_shift;
  logic             w_clear;
  logic [1:0]       w_dir;

  always_comb begin
    w_data_next = r_data;
    case (mode)
      MODE_HOLD: w_data_next = r_data;
      MODE_SHR:  w_data_next = {sin_r, r_data[WIDTH-1:1]};
      MODE_SHL:  w_data_next = {r_data[WIDTH-2:0], sin_l};
      MODE_LOAD: w_data_next = pin;
      default:   w_data_next = r_data;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_data <= '0;
    end else if (en) begin
      r_data <= w_data_next;
    end
  end

  assign w_shift = en && (mode == MODE_SHR || mode == MODE_SHL);
  assign w_clear = en && (mode == MODE_LOAD);
  assign w_dir   = mode_to_dir(mode);

  shift_word_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_word_counter (
    .clk         (clk),
    .rst         (rst),
    .i_shift     (w_shift),
    .i_dir       (w_dir),
    .i_clear     (w_clear),
    .o_word_done (word_done)
  );

  assign out    = r_data;
  assign sout_r = r_data[0];
  assign sout_l = r_data[WIDTH-1];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg at WIDTH=4: a run-length model checked
// every cycle, plus hand-computed literal expectations per scenario.
module tb_univ_shift_reg;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic         sin_r = 1'b0;
  logic         sin_l = 1'b0;
  logic [W-1:0] pin = '0;
  logic [W-1:0] out;
  logic         sout_r;
  logic         sout_l;
  logic         word_done;

  int checks = 0;
  int errors = 0;

  univ_shift_reg #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .mode      (mode),
    .sin_r     (sin_r),
    .sin_l     (sin_l),
    .pin       (pin),
    .out       (out),
    .sout_r    (sout_r),
    .sout_l    (sout_l),
    .word_done (word_done)
  );

  always #5 clk = ~clk;

  // Model: register as an integer, word tracking as the length of the
  // current same-direction run since the last load/reset (0 = no direction).
  int m_out   = 0;
  int m_run   = 0;
  int m_dir   = 0;
  int m_done  = 0;
  bit m_valid = 1'b0;

  always @(posedge clk) begin
    if (!rst) begin
      m_out = 0; m_run = 0; m_dir = 0; m_done = 0; m_valid = 1'b1;
    end else begin
      m_done = 0;
      if (en && mode == 2'b11) begin
        m_out = int'(pin); m_run = 0; m_dir = 0;
      end else if (en && (mode == 2'b01 || mode == 2'b10)) begin
        int d;
        d = (mode == 2'b01) ? 1 : 2;
        if (d == 1) m_out = m_out / 2 + (sin_r ? 8 : 0);
        else        m_out = (m_out * 2) % 16 + (sin_l ? 1 : 0);
        if (d == m_dir) m_run = m_run + 1;
        else begin m_run = 1; m_dir = d; end
        m_done = (m_run % W == 0) ? 1 : 0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      checks++;
      if (out !== W'(m_out) || sout_r !== m_out[0] || sout_l !== m_out[3] ||
          word_done !== m_done[0]) begin
        errors++;
        $display("FAIL model t=%0t out=%b sr=%b sl=%b wd=%b required out=%b sr=%b sl=%b wd=%b",
                 $time, out, sout_r, sout_l, word_done, W'(m_out), m_out[0], m_out[3], m_done[0]);
      end
    end
  end

  task automatic lit(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end else begin
      $display("check %s value=%b", name, act);
    end
  endtask

  task automatic step(input logic e, input logic [1:0] m, input logic sr, input logic sl,
                      input logic [W-1:0] p, input logic r);
    en = e; mode = m; sin_r = sr; sin_l = sl; pin = p; rst = r;
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [W-1:0] exp_r [4] = '{4'b1000, 4'b1100, 4'b0110, 4'b0011};
  logic         sr_seq [4] = '{1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    // 1. reset then right shifts
    step(1, 2'b01, 1, 1, 4'hF, 0);
    lit("reset_out", out, 4'b0000);
    lit("reset_wd", {3'b0, word_done}, 4'b0000);
    for (int i = 0; i < 4; i++) begin
      step(1, 2'b01, sr_seq[i], 0, 0, 1);
      lit("shr_out", out, exp_r[i]);
      lit("shr_wd", {3'b0, word_done}, (i == 3) ? 4'b0001 : 4'b0000);
    end

    // 2. load then left shift
    step(1, 2'b11, 0, 0, 4'b1010, 1);
    lit("load_sout_l", {3'b0, sout_l}, 4'b0001);
    step(1, 2'b10, 0, 1, 0, 1);
    lit("shl_out", out, 4'b0101);

    // 3. direction change mid-word
    step(1, 2'b11, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 2'b01, 1, 0, 0, 1);
    step(1, 2'b10, 0, 0, 0, 1);
    lit("dirchg_wd", {3'b0, word_done}, 4'b0000);
    for (int i = 0; i < 3; i++) step(1, 2'b10, 0, 1, 0, 1);
    lit("dirchg_out", out, 4'b0111);
    lit("dirchg_wd4", {3'b0, word_done}, 4'b0001);

    // 4. enable low mid-word
    step(1, 2'b11, 0, 0, 0, 1);
    step(1, 2'b01, 1, 0, 0, 1);
    step(1, 2'b01, 1, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 2'b01, i[0], 0, 0, 1);
    lit("en_low_out", out, 4'b1100);
    step(1, 2'b01, 0, 0, 0, 1);
    lit("resume_wd3", {3'b0, word_done}, 4'b0000);
    step(1, 2'b01, 0, 0, 0, 1);
    lit("resume_out", out, 4'b0011);
    lit("resume_wd4", {3'b0, word_done}, 4'b0001);

    // 5. reset and load preemption
    step(1, 2'b11, 0, 0, 0, 1);
    step(1, 2'b01, 1, 0, 0, 1);
    step(1, 2'b01, 1, 0, 0, 1);
    step(1, 2'b01, 1, 0, 0, 0);
    lit("midrst_out", out, 4'b0000);
    for (int i = 0; i < 3; i++) step(1, 2'b01, 1, 0, 0, 1);
    lit("pre_load_out", out, 4'b1110);
    step(1, 2'b11, 1, 0, 4'b0101, 1);
    lit("preempt_out", out, 4'b0101);
    lit("preempt_wd", {3'b0, word_done}, 4'b0000);
    step(1, 2'b01, 1, 0, 0, 1);
    lit("after_load_wd", {3'b0, word_done}, 4'b0000);

    // 6. back-to-back words
    step(1, 2'b11, 0, 0, 0, 1);
    for (int i = 1; i <= 8; i++) begin
      step(1, 2'b01, i[0], 0, 0, 1);
      lit("b2b_wd", {3'b0, word_done}, (i == 4 || i == 8) ? 4'b0001 : 4'b0000);
    end
    lit("b2b_out", out, 4'b0101);
    step(1, 2'b00, 1, 1, 4'hF, 1);
    lit("hold_wd", {3'b0, word_done}, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/univ_shift_reg.md
# univ_shift_reg

Parametrised universal shift register: the successor to the fixed 4-bit right-shift register. It supports hold, shift-right, shift-left and parallel load at any width, with separate serial inputs and outputs for each direction. It also has a word-boundary counter that pulses `word_done` once a full word has been shifted in one direction. It sits between serial links and parallel datapaths as a SIPO/PISO/bidirectional stage.

## Interface
Parameters:
- `WIDTH`, default 8: register width in bits; minimum 2.
- `CNT_W`, default `$clog2(WIDTH+1)`: width of the shift counter. It is derived and is never overridden.

Ports:
- `clk`, input, 1: the only clock. All state updates on the rising edge.
- `rst`, input, 1: synchronous, active-low reset.
- `en`, input, 1: operation enable. When low, all state holds.
- `mode`, input, 2: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
- `sin_r`, input, 1: serial input for shift right. Enters at the MSB.
- `sin_l`, input, 1: serial input for shift left. Enters at the LSB.
- `pin`, input, WIDTH: parallel load data.
- `out`, output, WIDTH: register contents (registered).
- `sout_r`, output, 1: `out[0]`, the bit that leaves on the next right shift.
- `sout_l`, output, 1: `out[WIDTH-1]`, the bit that leaves on the next left shift.
- `word_done`, output, 1: registered one-cycle pulse when WIDTH consecutive same-direction shifts complete.

## Operation
- Shift right: `out <= {sin_r, out[WIDTH-1:1]}`.
- Shift left: `out <= {out[WIDTH-2:0], sin_l}`.
- Parallel load: `out <= pin`, shift counter cleared to 0, direction state cleared.
- Hold (mode 00, or `en` = 0): `out`, the counter and the direction state are all unchanged. `word_done` is 0.
- Direction state: records the direction of the last shift, one of NONE, RIGHT or LEFT.
  - A shift in the same direction as the stored one, or with the state at NONE, increments the counter.
  - A shift in the opposite direction restarts the counter at 1 and updates the direction.
- Word completion: when a shift brings the counter to WIDTH:
  - the counter wraps to 0;
  - `word_done` = 1 for that one cycle;
  - the direction state is kept, so back-to-back words pulse every WIDTH shifts.
- `word_done` is 0 in every cycle that does not complete a word.
- Arithmetic: the counter is unsigned CNT_W bits and never exceeds WIDTH.

## Timing
- Reset values, applied on the first rising edge with `rst` = 0:
  - `out` = 0, `sout_r` = 0, `sout_l` = 0, `word_done` = 0;
  - counter = 0, direction = NONE.
- Reset takes priority over `en` and `mode`.
- Reset mid-word discards the partial count. No `word_done` is produced for that word.
- Latency:
  - `out`, the counter and `word_done` update on the same edge that samples `en`, `mode`, `sin_*` and `pin`.
  - `sout_r` and `sout_l` follow `out` combinationally and have no extra delay.
- Load on the same cycle the counter would otherwise reach WIDTH: load wins, the counter goes to 0 and `word_done` = 0.
- `sin_r` is ignored outside mode 01, `sin_l` outside mode 10, and `pin` outside mode 11.

## Structure
- Shared package `shift_pkg` holds:
  - mode localparams `MODE_HOLD`, `MODE_SHR`, `MODE_SHL`, `MODE_LOAD`;
  - direction encoding `DIR_NONE`, `DIR_RIGHT`, `DIR_LEFT`.
- One sub-module, `shift_word_counter`. It holds the counter and direction state and generates `word_done`.
  - Inputs: a shift strobe, the shift direction and a clear.
- The data register and mode mux live in the top level.

## Test plan
Directed scenarios, all with WIDTH = 4:
1. Reset and right shift:
   - Stimulus: `rst` low for one edge, then `en` = 1, mode 01, `sin_r` = 1,1,0,0 on successive edges.
   - Required: `out` = 0000 after reset, then 1000, 1100, 0110, 0011. `word_done` = 1 only after the fourth edge.
2. Load then left shift:
   - Stimulus: load `pin` = 1010, then mode 10 with `sin_l` = 1.
   - Required: `sout_l` = 1 before the shift, `out` = 0101 after it, counter = 1.
3. Direction change mid-word:
   - Stimulus: three right shifts, then one left shift, then three more left shifts.
   - Required: no pulse at the direction change. `word_done` fires after the 4th consecutive left shift.
4. Enable low:
   - Stimulus: `en` = 0 for 3 cycles mid-word with mode 01 and toggling `sin_r`.
   - Required: `out` and the count are frozen. Resuming completes the word after the remaining shifts only.
5. Reset and load preemption:
   - Stimulus: `rst` low after two shifts; separately, a load in place of the fourth shift.
   - Required: `out` = 0000 / `pin` respectively, and no `word_done` in either case.
6. Back-to-back words:
   - Stimulus: eight continuous right shifts.
   - Required: `word_done` pulses after shifts 4 and 8 only, each for exactly one cycle.
